// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - round-robin registered select generator for a 4-to-1 mux
`timescale 1ns/1ps

module mux_select_sequencer #(
    parameter int HOLD_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [1:0] s,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       tout
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_MAX);

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    s_q, s_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          tout_q, tout_d;

    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic [1:0]    cand;

    // Search starts just after the last winner; offset 4 wraps back onto ptr itself.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        tout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    s_d     = pick_idx;
                    gnt_d   = 4'b0001 << pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = CW'(1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // s is left untouched on grant end so the mux output stays put.
                if (rel || !req[s_q]) begin
                    gnt_d   = 4'b0000;
                    state_d = IDLE;
                end else if (cnt_q == HOLD_CNT) begin
                    gnt_d   = 4'b0000;
                    tout_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            s_q     <= 2'd0;
            gnt_q   <= 4'b0000;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            tout_q  <= tout_d;
        end
    end

    assign s    = s_q;
    assign gnt  = gnt_q;
    assign busy = |gnt_q;
    assign tout = tout_q;

endmodule
